rotate_tile_agen: RTL and testbench
===================================

# rotate_tile_agen

Parametrised tile address generator for the image rotation engine. It walks a source image in TILE x TILE pixel tiles and issues one bus burst command per tile row: first reading the tile, then writing it to its rotated (and optionally mirrored) destination position. It supports programmable strides and base addresses, and handshakes with the bus master and the tile buffer. Pixel reordering inside a tile is done by the tile buffer, which receives the effective mode from this block.

## Interface
- TILE, 8, tile edge in pixels (power of 2, ≥2)
- BPP, 3, bytes per pixel; TILE*BPP must be divisible by 4
- DIM_W, 16, width of height/width inputs
- ADDR_W, 32, address width
- MAX_DIM, 16383, largest legal height/width

Ports:
- I_RA_HCLK  in  1  clock
- I_RA_HRESET  in  1  reset, synchronous, active-high
- I_RA_START  in  1  start pulse, sampled only in IDLE
- I_RA_HEIGHT / I_RA_WIDTH  in  DIM_W  source size in pixels
- I_RA_DEGREES  in  2  0/90/180/270
- I_RA_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
- I_RA_MIRROR  in  1  horizontal flip of source before rotation
- I_RA_SRC_BASE / I_RA_DST_BASE  in  ADDR_W  byte base addresses
- I_RA_SRC_STRIDE / I_RA_DST_STRIDE  in  ADDR_W  row pitch in bytes
- I_RA_READY  in  1  bus accepts the current command
- I_RA_RD_DONE / I_RA_WR_DONE  in  1  tile buffer filled / drained (pulse)
- O_RA_ADDR  out  ADDR_W  burst start address
- O_RA_COUNT  out  5  beats per burst = TILE*BPP/4 while VALID, else 0
- O_RA_SIZE  out  3  3'h2 (32-bit) while VALID, else 0
- O_RA_WRITE  out  1  1 for write commands
- O_RA_VALID  out  1  command valid
- O_RA_ROT  out  2  latched effective clockwise angle
- O_RA_FLIP  out  1  latched mirror
- O_RA_BUSY / O_RA_DONE / O_RA_ERR  out  1  status; DONE and ERR are 1-cycle pulses

## Operation
- All outputs are registered. Reset forces every output to 0 and the FSM to IDLE, regardless of current state.
- On START in IDLE, all inputs are latched. Changes to the inputs during BUSY are ignored.
- If H = 0, W = 0, H > MAX_DIM or W > MAX_DIM, the block pulses ERR and stays in IDLE.
- Padded tile counts: HT = ceil(H/TILE), WT = ceil(W/TILE).
- Effective angle: a = DIRECTION ? DEGREES : (4 − DEGREES) mod 4.
- Tile order: ty outer (0..HT−1), tx inner (0..WT−1).
- Mirrored column: sx = MIRROR ? WT−1−tx : tx.
- Destination tile (dty, dtx) by angle:
  - a = 0: (ty, sx)
  - a = 1: (sx, HT−1−ty)
  - a = 2: (HT−1−ty, WT−1−sx)
  - a = 3: (WT−1−sx, ty)
- Read address, row k: SRC_BASE + (ty*TILE+k)*SRC_STRIDE + tx*TILE*BPP.
- Write address, row k: DST_BASE + (dty*TILE+k)*DST_STRIDE + dtx*TILE*BPP.
- k runs 0..TILE−1, ascending. Arithmetic is modulo 2^ADDR_W.
- FSM:
  - IDLE → RD_CMD on a legal START.
  - RD_CMD issues TILE commands, then → RD_WAIT.
  - RD_WAIT → WR_CMD on RD_DONE.
  - WR_CMD issues TILE commands, then → WR_WAIT.
  - WR_WAIT → RD_CMD (next tile) on WR_DONE, or → DONE after the last tile.
  - DONE → IDLE.
- BUSY = 1 in every state except IDLE.
- RD_DONE / WR_DONE are honoured only in the matching WAIT state. Pulses at any other time are ignored.

## Timing
- START at cycle n → VALID = 1 with the first read address at n+1.
- A command is accepted when VALID && READY. The next command is presented at the following cycle, so READY held high gives TILE back-to-back commands.
- While VALID && !READY, ADDR, WRITE and COUNT are held stable.
- VALID drops in the cycle after the last accept of a phase.
- DONE at cycle m → the first write command of the next tile is valid at m+1 (RD_DONE case); the next tile's reads are valid at m+1 (WR_DONE case).
- After the last WR_DONE at cycle m: DONE = 1 at m+1, BUSY = 0 and IDLE at m+2. START at m+2 is accepted.
- ERR is asserted the cycle after an illegal START.

## Test plan
- H=W=8, a=0, SRC_BASE=0x1000, SRC_STRIDE=24, DST_BASE=0x8000, DST_STRIDE=24, READY=1 → reads 0x1000, 0x1018 … 0x10A8 with COUNT=6 WRITE=0; writes 0x8000 … 0x80A8; DONE one cycle after WR_DONE.
- H=16, W=8, DEGREES=1, DIRECTION=1, DST_STRIDE=48 → tile ty=0 writes start at 0x8018, step 48; tile ty=1 writes start at 0x8000; ROT=1.
- Same image with DEGREES=3, DIRECTION=0 → address sequence identical to the previous test; ROT=1.
- H=W=10, a=2, MIRROR=1 → HT=WT=2 (4 tiles); tile (0,0) writes to dest tile (1,0); no command is issued beyond tile index 1.
- READY toggled 1-0-0-1 mid-phase, and RD_DONE pulsed during RD_CMD → address held while stalled, no skipped row; the early RD_DONE is ignored and the block waits for a second RD_DONE.
- W=0 → ERR pulse, BUSY stays 0.
- HRESET high during WR_CMD → all outputs 0 the next cycle; a new START then runs normally from tile 0.

Source files
------------

// File: rtl/rotate_tile_agen.sv
// Tile address generator: per tile, TILE read bursts then TILE write bursts to the rotated/mirrored spot.
// First command one cycle after START; commands hold while VALID && !READY; waits for tile-buffer done pulses.
module rotate_tile_agen #(
   parameter int TILE    = 8,
   parameter int BPP     = 3,
   parameter int DIM_W   = 16,
   parameter int ADDR_W  = 32,
   parameter int MAX_DIM = 16383
) (
   input  logic              I_RA_HCLK,
   input  logic              I_RA_HRESET,
   input  logic              I_RA_START,
   input  logic [DIM_W-1:0]  I_RA_HEIGHT,
   input  logic [DIM_W-1:0]  I_RA_WIDTH,
   input  logic [1:0]        I_RA_DEGREES,
   input  logic              I_RA_DIRECTION,
   input  logic              I_RA_MIRROR,
   input  logic [ADDR_W-1:0] I_RA_SRC_BASE,
   input  logic [ADDR_W-1:0] I_RA_DST_BASE,
   input  logic [ADDR_W-1:0] I_RA_SRC_STRIDE,
   input  logic [ADDR_W-1:0] I_RA_DST_STRIDE,
   input  logic              I_RA_READY,
   input  logic              I_RA_RD_DONE,
   input  logic              I_RA_WR_DONE,
   output logic [ADDR_W-1:0] O_RA_ADDR,
   output logic [4:0]        O_RA_COUNT,
   output logic [2:0]        O_RA_SIZE,
   output logic              O_RA_WRITE,
   output logic              O_RA_VALID,
   output logic [1:0]        O_RA_ROT,
   output logic              O_RA_FLIP,
   output logic              O_RA_BUSY,
   output logic              O_RA_DONE,
   output logic              O_RA_ERR
);

   localparam int                KW       = $clog2(TILE);
   localparam logic [4:0]        BEATS    = 5'(TILE * BPP / 4);
   localparam logic [ADDR_W-1:0] TILE_A   = ADDR_W'(TILE);
   localparam logic [ADDR_W-1:0] TBYTES_A = ADDR_W'(TILE * BPP);
   localparam logic [KW-1:0]     K_LAST   = KW'(TILE - 1);
   localparam logic [KW-1:0]     K_ONE    = KW'(1);
   localparam logic [DIM_W-1:0]  ONE_D    = DIM_W'(1);
   localparam logic [DIM_W:0]    MAX_D    = (DIM_W + 1)'(MAX_DIM);
   localparam logic [DIM_W:0]    RND_D    = (DIM_W + 1)'(TILE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CMD,
      S_RD_WAIT,
      S_WR_CMD,
      S_WR_WAIT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [DIM_W-1:0]  ht, wt, ty, tx, ty_nxt, tx_nxt;
   logic [KW-1:0]     k, k_nxt;
   logic [ADDR_W-1:0] src_base, dst_base, src_stride, dst_stride;
   logic              valid_nxt, write_nxt, done_nxt, err_nxt;
   logic              accept, start_bad, last_tile;
   logic [1:0]        rot_in;
   logic [DIM_W-1:0]  ht_in, wt_in;

   logic [DIM_W-1:0]  sx, dty, dtx, row_t, col_t;
   logic [ADDR_W-1:0] base_t, stride_t, cmd_addr;

   assign start_bad = (I_RA_HEIGHT == '0) || (I_RA_WIDTH == '0) ||
                      ({1'b0, I_RA_HEIGHT} > MAX_D) || ({1'b0, I_RA_WIDTH} > MAX_D);
   assign ht_in     = DIM_W'(({1'b0, I_RA_HEIGHT} + RND_D) >> KW);
   assign wt_in     = DIM_W'(({1'b0, I_RA_WIDTH} + RND_D) >> KW);
   // counter-clockwise turns are folded into the equivalent clockwise angle
   assign rot_in    = I_RA_DIRECTION ? I_RA_DEGREES : 2'd0 - I_RA_DEGREES;
   assign accept    = O_RA_VALID && I_RA_READY;
   assign last_tile = (ty == ht - ONE_D) && (tx == wt - ONE_D);

   always_comb begin
      state_nxt = state;
      ty_nxt    = ty;
      tx_nxt    = tx;
      k_nxt     = k;
      valid_nxt = O_RA_VALID;
      write_nxt = O_RA_WRITE;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (I_RA_START) begin
               if (start_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = S_RD_CMD;
                  ty_nxt    = '0;
                  tx_nxt    = '0;
                  k_nxt     = '0;
                  valid_nxt = 1'b1;
                  write_nxt = 1'b0;
               end
            end
         end
         S_RD_CMD, S_WR_CMD: begin
            if (accept) begin
               if (k == K_LAST) begin
                  k_nxt     = '0;
                  valid_nxt = 1'b0;
                  write_nxt = 1'b0;
                  state_nxt = (state == S_RD_CMD) ? S_RD_WAIT : S_WR_WAIT;
               end else begin
                  k_nxt = k + K_ONE;
               end
            end
         end
         S_RD_WAIT: begin
            if (I_RA_RD_DONE) begin
               state_nxt = S_WR_CMD;
               valid_nxt = 1'b1;
               write_nxt = 1'b1;
            end
         end
         S_WR_WAIT: begin
            if (I_RA_WR_DONE) begin
               if (last_tile) begin
                  state_nxt = S_DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = S_RD_CMD;
                  valid_nxt = 1'b1;
                  write_nxt = 1'b0;
                  if (tx == wt - ONE_D) begin
                     tx_nxt = '0;
                     ty_nxt = ty + ONE_D;
                  end else begin
                     tx_nxt = tx + ONE_D;
                  end
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // address of the command that will be presented next cycle
   always_comb begin
      sx       = O_RA_FLIP ? (wt - ONE_D - tx_nxt) : tx_nxt;
      dty      = ty_nxt;
      dtx      = sx;
      case (O_RA_ROT)
         2'd1: begin
            dty = sx;
            dtx = ht - ONE_D - ty_nxt;
         end
         2'd2: begin
            dty = ht - ONE_D - ty_nxt;
            dtx = wt - ONE_D - sx;
         end
         2'd3: begin
            dty = wt - ONE_D - sx;
            dtx = ty_nxt;
         end
         default: begin
            dty = ty_nxt;
            dtx = sx;
         end
      endcase
      row_t    = write_nxt ? dty : ty_nxt;
      col_t    = write_nxt ? dtx : tx_nxt;
      base_t   = write_nxt ? dst_base : src_base;
      stride_t = write_nxt ? dst_stride : src_stride;
      cmd_addr = base_t + (ADDR_W'(row_t) * TILE_A + ADDR_W'(k_nxt)) * stride_t
                 + ADDR_W'(col_t) * TBYTES_A;
   end

   always_ff @(posedge I_RA_HCLK) begin
      if (I_RA_HRESET) begin
         state      <= S_IDLE;
         ty         <= '0;
         tx         <= '0;
         k          <= '0;
         ht         <= '0;
         wt         <= '0;
         src_base   <= '0;
         dst_base   <= '0;
         src_stride <= '0;
         dst_stride <= '0;
         O_RA_ADDR  <= '0;
         O_RA_COUNT <= '0;
         O_RA_SIZE  <= '0;
         O_RA_WRITE <= 1'b0;
         O_RA_VALID <= 1'b0;
         O_RA_ROT   <= '0;
         O_RA_FLIP  <= 1'b0;
         O_RA_BUSY  <= 1'b0;
         O_RA_DONE  <= 1'b0;
         O_RA_ERR   <= 1'b0;
      end else begin
         state <= state_nxt;
         ty    <= ty_nxt;
         tx    <= tx_nxt;
         k     <= k_nxt;
         if (state == S_IDLE && I_RA_START && !start_bad) begin
            ht         <= ht_in;
            wt         <= wt_in;
            src_base   <= I_RA_SRC_BASE;
            dst_base   <= I_RA_DST_BASE;
            src_stride <= I_RA_SRC_STRIDE;
            dst_stride <= I_RA_DST_STRIDE;
            O_RA_ROT   <= rot_in;
            O_RA_FLIP  <= I_RA_MIRROR;
         end
         // first read of a job is row 0 of tile 0, i.e. the source base itself
         if (valid_nxt) begin
            O_RA_ADDR <= (state == S_IDLE) ? I_RA_SRC_BASE : cmd_addr;
         end
         O_RA_VALID <= valid_nxt;
         O_RA_WRITE <= write_nxt;
         O_RA_COUNT <= valid_nxt ? BEATS : 5'd0;
         O_RA_SIZE  <= valid_nxt ? 3'h2 : 3'h0;
         O_RA_BUSY  <= (state_nxt != S_IDLE);
         O_RA_DONE  <= done_nxt;
         O_RA_ERR   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_rotate_tile_agen.sv
// Bench for rotate_tile_agen: randomized jobs checked against a geometric tile-rotation model.
module tb_rotate_tile_agen;

   localparam int TILE = 8;
   localparam int BPP  = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] height, width;
   logic [1:0]  degrees;
   logic        direction, mirror;
   logic [31:0] src_base, dst_base, src_stride, dst_stride;
   logic        ready, rd_done, wr_done;
   logic [31:0] addr;
   logic [4:0]  count;
   logic [2:0]  size;
   logic        write, valid;
   logic [1:0]  rot;
   logic        flip, busy, done, err;

   always #5 clk = ~clk;

   rotate_tile_agen dut (
      .I_RA_HCLK(clk), .I_RA_HRESET(rst), .I_RA_START(start),
      .I_RA_HEIGHT(height), .I_RA_WIDTH(width), .I_RA_DEGREES(degrees),
      .I_RA_DIRECTION(direction), .I_RA_MIRROR(mirror),
      .I_RA_SRC_BASE(src_base), .I_RA_DST_BASE(dst_base),
      .I_RA_SRC_STRIDE(src_stride), .I_RA_DST_STRIDE(dst_stride),
      .I_RA_READY(ready), .I_RA_RD_DONE(rd_done), .I_RA_WR_DONE(wr_done),
      .O_RA_ADDR(addr), .O_RA_COUNT(count), .O_RA_SIZE(size), .O_RA_WRITE(write),
      .O_RA_VALID(valid), .O_RA_ROT(rot), .O_RA_FLIP(flip), .O_RA_BUSY(busy),
      .O_RA_DONE(done), .O_RA_ERR(err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_addr[$];
   bit          exp_wr[$];
   int          exp_rot;

   logic [31:0] obs_addr[$];
   logic        obs_wr[$];
   logic [4:0]  obs_cnt[$];
   logic [2:0]  obs_size[$];
   logic [1:0]  obs_rot;
   logic        obs_flip;
   logic        first_valid;
   int          hold_viol, drop_viol, resume_viol, done_gap, idle_gap;
   bit          timed_out;

   // Destination tile found by mirroring, then turning the tile grid 90 degrees clockwise a times.
   task automatic build_model(input int h, input int w, input int deg, input int dir, input int mir,
                              input logic [31:0] sb, input logic [31:0] db,
                              input logic [31:0] ss, input logic [31:0] ds);
      int ht, wt, a, r, c, rr, cc, nr, tmp;
      logic [31:0] v;
      exp_addr.delete();
      exp_wr.delete();
      ht = (h + TILE - 1) / TILE;
      wt = (w + TILE - 1) / TILE;
      a  = dir ? deg : (4 - deg) % 4;
      exp_rot = a;
      for (int ty = 0; ty < ht; ty++) begin
         for (int tx = 0; tx < wt; tx++) begin
            r  = ty;
            c  = mir ? wt - 1 - tx : tx;
            rr = ht;
            cc = wt;
            for (int t = 0; t < a; t++) begin
               nr  = c;
               c   = rr - 1 - r;
               r   = nr;
               tmp = rr;
               rr  = cc;
               cc  = tmp;
            end
            for (int k = 0; k < TILE; k++) begin
               v = sb + 32'(ty * TILE + k) * ss + 32'(tx * TILE * BPP);
               exp_addr.push_back(v);
               exp_wr.push_back(1'b0);
            end
            for (int k = 0; k < TILE; k++) begin
               v = db + 32'(r * TILE + k) * ds + 32'(c * TILE * BPP);
               exp_addr.push_back(v);
               exp_wr.push_back(1'b1);
            end
         end
      end
   endtask

   // Drives one job to completion, acting as bus master and tile buffer; records what the DUT issued.
   task automatic run_job(input int h, input int w, input int deg, input int dir, input int mir,
                          input logic [31:0] sb, input logic [31:0] db,
                          input logic [31:0] ss, input logic [31:0] ds,
                          input int ready_pct, input bit early);
      int acc, tiles, total, cyc, wr_last, done_cyc, idle_cyc;
      bit last_wr, pulsed, did_early, prev_stall, r;
      logic [31:0] prev_addr;
      build_model(h, w, deg, dir, mir, sb, db, ss, ds);
      total = ((h + TILE - 1) / TILE) * ((w + TILE - 1) / TILE);
      obs_addr.delete(); obs_wr.delete(); obs_cnt.delete(); obs_size.delete();
      hold_viol = 0; drop_viol = 0; resume_viol = 0;
      height = 16'(h); width = 16'(w); degrees = 2'(deg); direction = 1'(dir); mirror = 1'(mir);
      src_base = sb; dst_base = db; src_stride = ss; dst_stride = ds;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // scramble the job inputs: they must have been captured at START
      height = 16'($urandom); width = 16'($urandom); degrees = 2'($urandom);
      direction = 1'($urandom); mirror = 1'($urandom);
      src_base = $urandom; dst_base = $urandom; src_stride = $urandom; dst_stride = $urandom;
      first_valid = valid;
      obs_rot = rot;
      obs_flip = flip;
      acc = 0; tiles = 0; cyc = 0; wr_last = -100; done_cyc = -1; idle_cyc = -1;
      last_wr = 0; pulsed = 0; did_early = 0; prev_stall = 0; prev_addr = '0;
      while (cyc < 8000) begin
         rd_done = 1'b0;
         wr_done = 1'b0;
         if (pulsed && !valid) resume_viol++;
         pulsed = 0;
         if (done && done_cyc < 0) done_cyc = cyc;
         if (done_cyc >= 0 && !busy) begin
            idle_cyc = cyc;
            break;
         end
         if (prev_stall && valid && ({write, addr} !== {last_wr, prev_addr})) hold_viol++;
         if (acc == TILE) begin
            prev_stall = 0;
            ready = 1'($urandom);
            if (valid) drop_viol++;
            else if ($urandom_range(0, 1) == 1) begin
               acc = 0;
               if (last_wr) begin
                  wr_done = 1'b1;
                  tiles++;
                  if (tiles == total) wr_last = cyc;
                  else pulsed = 1;
               end else begin
                  rd_done = 1'b1;
                  pulsed = 1;
               end
            end
         end else begin
            r = ($urandom_range(0, 99) < ready_pct);
            ready = r;
            if (valid && r) begin
               obs_addr.push_back(addr);
               obs_wr.push_back(write);
               obs_cnt.push_back(count);
               obs_size.push_back(size);
               acc++;
            end
            if (valid) last_wr = write;
            if (early && !did_early && valid && !write && acc == 3) begin
               rd_done = 1'b1;
               did_early = 1;
            end
            prev_stall = valid && !r;
            prev_addr = addr;
         end
         @(posedge clk); #1;
         cyc++;
      end
      ready = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
      timed_out = (idle_cyc < 0);
      done_gap = done_cyc - wr_last;
      idle_gap = idle_cyc - wr_last;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; height = '0; width = '0; degrees = '0; direction = 1'b0;
      mirror = 1'b0; src_base = '0; dst_base = '0; src_stride = '0; dst_stride = '0;
      ready = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL reset_done_err got=%b want=00", {done, err}); end
      n_checks++; if ({addr, count, size, write, rot, flip} !== 44'h0) begin
         n_fail++; $display("FAIL reset_cmd got=%h want=0", {addr, count, size, write, rot, flip});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] e;
      run_job(8, 8, 0, 1, 0, 32'h1000, 32'h8000, 32'd24, 32'd24, 100, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got=stuck want=idle"); end
      n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid got=%b want=1", first_valid); end
      n_checks++; if (obs_addr.size() !== 16) begin n_fail++; $display("FAIL basic_cmd_count got=%0d want=16", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < 16; i++) begin
         e = (i < 8) ? 32'h1000 + 32'(24 * i) : 32'h8000 + 32'(24 * (i - 8));
         n_checks++;
         if ({obs_wr[i], obs_cnt[i], obs_size[i], obs_addr[i]} !== {(i >= 8), 5'd6, 3'd2, e}) begin
            n_fail++;
            $display("FAIL basic_cmd[%0d] got wr=%b cnt=%0d size=%0d addr=%h want wr=%b cnt=6 size=2 addr=%h",
                     i, obs_wr[i], obs_cnt[i], obs_size[i], obs_addr[i], (i >= 8), e);
         end
      end
      n_checks++; if (done_gap !== 1) begin n_fail++; $display("FAIL basic_done_latency got=%0d want=1", done_gap); end
      n_checks++; if (idle_gap !== 2) begin n_fail++; $display("FAIL basic_idle_latency got=%0d want=2", idle_gap); end
      n_checks++; if (obs_rot !== 2'd0) begin n_fail++; $display("FAIL basic_rot got=%0d want=0", obs_rot); end
      n_checks++; if (drop_viol !== 0) begin n_fail++; $display("FAIL basic_valid_drop got=%0d want=0", drop_viol); end
   endtask

   task automatic test_rot90_cw;
      run_job(16, 8, 1, 1, 0, 32'h1000, 32'h8000, 32'd24, 32'd48, 100, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL rot90_timeout got=stuck want=idle"); end
      n_checks++; if (obs_addr.size() !== exp_addr.size()) begin
         n_fail++; $display("FAIL rot90_cmd_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if ({obs_wr[i], obs_cnt[i], obs_size[i], obs_addr[i]} !== {exp_wr[i], 5'd6, 3'd2, exp_addr[i]}) begin
            n_fail++; $display("FAIL rot90_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                               i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
         end
      end
      if (obs_addr.size() == 32) begin
         n_checks++; if (obs_addr[8] !== 32'h8018) begin n_fail++; $display("FAIL rot90_tile0_wr got=%h want=8018", obs_addr[8]); end
         n_checks++; if (obs_addr[9] !== 32'h8048) begin n_fail++; $display("FAIL rot90_tile0_row1 got=%h want=8048", obs_addr[9]); end
         n_checks++; if (obs_addr[24] !== 32'h8000) begin n_fail++; $display("FAIL rot90_tile1_wr got=%h want=8000", obs_addr[24]); end
      end
      n_checks++; if (obs_rot !== 2'd1) begin n_fail++; $display("FAIL rot90_rot got=%0d want=1", obs_rot); end
      n_checks++; if (resume_viol !== 0) begin n_fail++; $display("FAIL rot90_resume got=%0d want=0", resume_viol); end
   endtask

   task automatic test_rot270_ccw;
      run_job(16, 8, 3, 0, 0, 32'h1000, 32'h8000, 32'd24, 32'd48, 70, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL ccw270_timeout got=stuck want=idle"); end
      n_checks++; if (obs_addr.size() !== exp_addr.size()) begin
         n_fail++; $display("FAIL ccw270_cmd_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if ({obs_wr[i], obs_addr[i]} !== {exp_wr[i], exp_addr[i]}) begin
            n_fail++; $display("FAIL ccw270_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                               i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
         end
      end
      if (obs_addr.size() == 32) begin
         n_checks++; if (obs_addr[8] !== 32'h8018) begin n_fail++; $display("FAIL ccw270_tile0_wr got=%h want=8018", obs_addr[8]); end
         n_checks++; if (obs_addr[24] !== 32'h8000) begin n_fail++; $display("FAIL ccw270_tile1_wr got=%h want=8000", obs_addr[24]); end
      end
      n_checks++; if (obs_rot !== 2'd1) begin n_fail++; $display("FAIL ccw270_rot got=%0d want=1", obs_rot); end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL ccw270_hold got=%0d want=0", hold_viol); end
   endtask

   task automatic test_mirror_180;
      run_job(10, 10, 2, 1, 1, 32'h2000, 32'h9000, 32'd30, 32'd30, 100, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL mirror_timeout got=stuck want=idle"); end
      n_checks++; if (obs_addr.size() !== 64) begin n_fail++; $display("FAIL mirror_cmd_count got=%0d want=64", obs_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if ({obs_wr[i], obs_addr[i]} !== {exp_wr[i], exp_addr[i]}) begin
            n_fail++; $display("FAIL mirror_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                               i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
         end
      end
      if (obs_addr.size() > 8) begin
         n_checks++;
         if (obs_addr[8] !== 32'h9000 + 32'd240) begin
            n_fail++; $display("FAIL mirror_tile00_dest got=%h want=%h", obs_addr[8], 32'h9000 + 32'd240);
         end
      end
      n_checks++; if ({obs_flip, obs_rot} !== 3'b110) begin n_fail++; $display("FAIL mirror_flip_rot got=%b want=110", {obs_flip, obs_rot}); end
   endtask

   task automatic test_stall_early_done;
      run_job(16, 16, 1, 0, 0, $urandom, $urandom, 32'd512, 32'd640, 50, 1);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got=stuck want=idle"); end
      n_checks++; if (obs_addr.size() !== exp_addr.size()) begin
         n_fail++; $display("FAIL stall_cmd_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if ({obs_wr[i], obs_addr[i]} !== {exp_wr[i], exp_addr[i]}) begin
            n_fail++; $display("FAIL stall_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                               i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
         end
      end
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d want=0", hold_viol); end
      n_checks++; if (drop_viol !== 0) begin n_fail++; $display("FAIL stall_valid_drop got=%0d want=0", drop_viol); end
      n_checks++; if (obs_rot !== 2'd3) begin n_fail++; $display("FAIL stall_rot got=%0d want=3", obs_rot); end
   endtask

   task automatic test_illegal;
      logic [15:0] hs[2];
      logic [15:0] ws[2];
      hs[0] = 16'd8;     ws[0] = 16'd0;
      hs[1] = 16'd16384; ws[1] = 16'd8;
      for (int j = 0; j < 2; j++) begin
         height = hs[j]; width = ws[j]; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n_checks++; if ({err, busy, valid} !== 3'b100) begin
            n_fail++; $display("FAIL illegal%0d_err got=%b want=100 (err,busy,valid)", j, {err, busy, valid});
         end
         @(posedge clk); #1;
         n_checks++; if ({err, busy} !== 2'b00) begin
            n_fail++; $display("FAIL illegal%0d_after got=%b want=00 (err,busy)", j, {err, busy});
         end
      end
   endtask

   task automatic test_reset_mid_write;
      bit reached;
      height = 16'd16; width = 16'd16; degrees = 2'd1; direction = 1'b1; mirror = 1'b1;
      src_base = 32'h100; dst_base = 32'h4000; src_stride = 32'd48; dst_stride = 32'd48;
      ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      reached = 0;
      for (int i = 0; i < 200; i++) begin
         if (valid && write) begin
            reached = 1;
            break;
         end
         rd_done = busy && !valid;
         @(posedge clk); #1;
      end
      rd_done = 1'b0;
      n_checks++; if (!reached) begin n_fail++; $display("FAIL rstmid_reach_write got=no want=yes"); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ready = 1'b0;
      n_checks++; if ({addr, count, size, write, valid, rot, flip, busy, done, err} !== 48'h0) begin
         n_fail++; $display("FAIL rstmid_outputs got=%h want=0", {addr, count, size, write, valid, rot, flip, busy, done, err});
      end
      run_job(16, 8, 2, 1, 0, 32'h3000, 32'h7000, 32'd24, 32'd24, 80, 0);
      n_checks++; if (timed_out) begin n_fail++; $display("FAIL rstmid_timeout got=stuck want=idle"); end
      n_checks++; if (obs_addr.size() !== exp_addr.size()) begin
         n_fail++; $display("FAIL rstmid_cmd_count got=%0d want=%0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
         n_checks++;
         if ({obs_wr[i], obs_addr[i]} !== {exp_wr[i], exp_addr[i]}) begin
            n_fail++; $display("FAIL rstmid_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                               i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      int h, w, dg, dr, mr;
      for (int j = 0; j < 6; j++) begin
         h  = $urandom_range(1, 40);
         w  = $urandom_range(1, 40);
         dg = $urandom_range(0, 3);
         dr = $urandom_range(0, 1);
         mr = $urandom_range(0, 1);
         run_job(h, w, dg, dr, mr, $urandom, $urandom, $urandom, $urandom, $urandom_range(30, 100), 0);
         n_checks++; if (timed_out) begin n_fail++; $display("FAIL b2b%0d_timeout got=stuck want=idle", j); end
         n_checks++; if (first_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_first_valid got=%b want=1", j, first_valid); end
         n_checks++; if (obs_addr.size() !== exp_addr.size()) begin
            n_fail++; $display("FAIL b2b%0d_cmd_count got=%0d want=%0d", j, obs_addr.size(), exp_addr.size());
         end
         for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if ({obs_wr[i], obs_cnt[i], obs_size[i], obs_addr[i]} !== {exp_wr[i], 5'd6, 3'd2, exp_addr[i]}) begin
               n_fail++; $display("FAIL b2b%0d_cmd[%0d] got wr=%b addr=%h want wr=%b addr=%h",
                                  j, i, obs_wr[i], obs_addr[i], exp_wr[i], exp_addr[i]);
            end
         end
         n_checks++; if ({obs_flip, obs_rot} !== {1'(mr), 2'(exp_rot)}) begin
            n_fail++; $display("FAIL b2b%0d_mode got=%b want=%b", j, {obs_flip, obs_rot}, {1'(mr), 2'(exp_rot)});
         end
         n_checks++; if ({done_gap, idle_gap} !== {32'sd1, 32'sd2}) begin
            n_fail++; $display("FAIL b2b%0d_done_timing got=%0d/%0d want=1/2", j, done_gap, idle_gap);
         end
         n_checks++; if (hold_viol + drop_viol + resume_viol !== 0) begin
            n_fail++; $display("FAIL b2b%0d_handshake got=%0d/%0d/%0d want=0/0/0", j, hold_viol, drop_viol, resume_viol);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rot90_cw();
      test_rot270_ccw();
      test_mirror_180();
      test_stall_early_done();
      test_illegal();
      test_reset_mid_write();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
